// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared encodings and types for the in-order pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  localparam int          REG_ADDR_W    = 5;
  localparam logic [31:0] NOP_INSTR     = 32'h00000013;  // addi x0, x0, 0
  localparam int          SAT_W_DEFAULT = 16;

  // Encoding 2'd3 is deliberately unused; the FSM steers it back to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  // One in-flight destination register: does the stage hold a real writer, and of which register.
  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

  // A source matches an in-flight writer only when the entry is live and the register numbers agree.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.vld && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Purpose: tracks destination registers of the instructions in EX/MEM/WB and flags RAW hazards in ID.
// Latency: hazard_o is combinational from the ID fields; scoreboard advances one stage per clock.
// Backpressure: bubble_i replaces the EX entry with an empty slot while ID is held.
//
// Ports:
//   clock, reset_n        pipeline clock, async active-low reset
//   id_*_i                decoded fields of the instruction currently in ID
//   bubble_i              ID/EX is loading a bubble this cycle
//   detect_en_i           0 masks hazard detection (used while the flushed bubble sits in ID)
//   hazard_o              ID instruction reads a register still being produced downstream
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  bubble_i,
  input  logic                  detect_en_i,
  output logic                  hazard_o
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d;
  logic      rs1_hit, rs2_hit;

  // x0 is hard-wired zero, so a write to it never needs tracking.
  always_comb begin
    ex_d = '0;
    if (!bubble_i) begin
      ex_d.vld = id_valid_i && id_reg_write_i && (id_rd_i != '0);
      ex_d.rd  = id_rd_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  // No forwarding network exists, so a producer anywhere up to and including WB blocks the reader.
  always_comb begin
    rs1_hit = id_rs1_used_i && (id_rs1_i != '0) &&
              (sb_hit(ex_q, id_rs1_i) || sb_hit(mem_q, id_rs1_i) || sb_hit(wb_q, id_rs1_i));
    rs2_hit = id_rs2_used_i && (id_rs2_i != '0) &&
              (sb_hit(ex_q, id_rs2_i) || sb_hit(mem_q, id_rs2_i) || sb_hit(wb_q, id_rs2_i));
    hazard_o = id_valid_i && detect_en_i && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Purpose: stall/flush control for a 5-stage in-order pipeline without forwarding, plus perf counters.
// Latency: hold/flush/bubble are combinational in the same cycle; state and counters update next edge.
// Backpressure: a RAW hazard holds PC and IF/ID and bubbles ID/EX; a taken branch overrides the stall.
//
// Ports:
//   clock, reset_n                     pipeline clock, async active-low reset
//   id_valid, id_rs1/2, id_rs1/2_used  source side of the ID instruction
//   id_rd, id_reg_write                destination side of the ID instruction
//   ex_take_branch                     branch resolved taken in EX
//   cnt_clear                          synchronous clear of both counters
//   pc_hold, if_id_hold                freeze front end
//   if_id_flush, id_ex_bubble          squash IF/ID, inject bubble into ID/EX
//   ctrl_state                         RUN / STALL / FLUSH
//   stall_cycles, flush_events         saturating performance counters
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int SAT_W = SAT_W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  ex_take_branch,
  input  logic                  cnt_clear,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [1:0]            ctrl_state,
  output logic [SAT_W-1:0]      stall_cycles,
  output logic [SAT_W-1:0]      flush_events
);

  localparam logic [SAT_W-1:0] CNT_MAX = {SAT_W{1'b1}};

  ctrl_state_e      state_q, state_d;
  logic             hazard;
  logic             detect_en;
  logic             stall;
  logic [SAT_W-1:0] stall_q, stall_d;
  logic [SAT_W-1:0] flush_q, flush_d;

  // The cycle after a flush, ID holds the squashed bubble; ignore whatever the decoder presents.
  assign detect_en = (state_q != ST_FLUSH);

  hazard_scoreboard u_scoreboard (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_used_i  (id_rs2_used),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .bubble_i       (id_ex_bubble),
    .detect_en_i    (detect_en),
    .hazard_o       (hazard)
  );

  // Branch wins over hazard: the PC must be free to load the target.
  // Outputs are gated by reset_n so the pipeline sees no control activity while in reset.
  always_comb begin
    stall        = hazard && !ex_take_branch;
    pc_hold      = reset_n && stall;
    if_id_hold   = reset_n && stall;
    if_id_flush  = reset_n && ex_take_branch;
    id_ex_bubble = reset_n && (stall || ex_take_branch);
  end

  // Next state depends only on inputs, so the unused encoding falls back to ST_RUN on the next edge.
  always_comb begin
    state_d = ST_RUN;
    if (ex_take_branch) begin
      state_d = ST_FLUSH;
    end else if (hazard) begin
      state_d = ST_STALL;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (pc_hold && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + 1'b1;
      end
      if (ex_take_branch && (flush_q != CNT_MAX)) begin
        flush_d = flush_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Purpose: self-checking bench for pipeline_hazard_controller (SAT_W=4 so saturation is reachable).
// Latency: expected control outputs are queued when a cycle is driven and compared at its falling edge.
// Backpressure: n/a.
module tb_pipeline_hazard_controller;

  localparam int SW = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       w;
    logic       br;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic hold;
    logic flush;
    logic bubble;
  } exp_t;

  localparam exp_t E_NONE  = 3'b000;
  localparam exp_t E_STALL = 3'b101;
  localparam exp_t E_BR    = 3'b011;

  logic          clock;
  logic          reset_n;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_reg_write;
  logic          ex_take_branch, cnt_clear;
  logic          pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
  logic [1:0]    ctrl_state;
  logic [SW-1:0] stall_cycles, flush_events;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  pipeline_hazard_controller #(.SAT_W(SW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .ex_take_branch (ex_take_branch),
    .cnt_clear      (cnt_clear),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .ctrl_state     (ctrl_state),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic w, input logic br, input logic clr);
    stim_t s;
    s = '{v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, w: w, br: br, clr: clr};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_valid       = s.v;
    id_rs1         = s.rs1;
    id_rs1_used    = s.u1;
    id_rs2         = s.rs2;
    id_rs2_used    = s.u2;
    id_rd          = s.rd;
    id_reg_write   = s.w;
    ex_take_branch = s.br;
    cnt_clear      = s.clr;
  endtask

  // One pipeline cycle: drive after the rising edge, record what should come out, stop at the falling edge.
  task automatic drive(input stim_t s, input exp_t e);
    @(posedge clock);
    #1;
    apply(s);
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Drain the scoreboard with idle cycles and clear the counters on the last one.
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, (i == 3)));
    end
  endtask

  task automatic test_reset();
    apply(mk(1, 5, 1, 5, 1, 5, 1, 1, 0));
    reset_n = 1'b0;
    #3;
    checks++;
    if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000",
               {pc_hold, if_id_hold, if_id_flush, id_ex_bubble});
    end
    checks++;
    if (ctrl_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", ctrl_state);
    end
    checks++;
    if ({stall_cycles, flush_events} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d required 0/0", stall_cycles, flush_events);
    end
    repeat (2) @(negedge clock);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  e;
    settle();
    st[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0); ex[0] = E_NONE;
    for (int i = 1; i <= 3; i++) begin
      st[i] = mk(1, 5, 1, 0, 0, 6, 1, 0, 0); ex[i] = E_STALL;
    end
    st[4] = mk(1, 5, 1, 0, 0, 6, 1, 0, 0); ex[4] = E_NONE;
    st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); ex[5] = E_NONE;
    for (int i = 0; i < 6; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL b2b cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
      if (i == 2) begin
        checks++;
        if (ctrl_state !== 2'd1) begin
          errors++;
          $display("FAIL b2b_state: got %0d required 1", ctrl_state);
        end
      end
    end
    checks++;
    if (stall_cycles !== 4'd3) begin
      errors++;
      $display("FAIL b2b_stall_cycles: got %0d required 3", stall_cycles);
    end
  endtask

  task automatic test_distance();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    stim_t wr, fl, rdr;
    wr  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0);
    fl  = mk(1, 0, 0, 0, 0, 9, 1, 0, 0);
    rdr = mk(1, 0, 0, 7, 1, 0, 0, 0, 0);
    settle();
    // distance 2: two stall cycles
    st.push_back(wr);  ex.push_back(E_NONE);
    st.push_back(fl);  ex.push_back(E_NONE);
    st.push_back(rdr); ex.push_back(E_STALL);
    st.push_back(rdr); ex.push_back(E_STALL);
    st.push_back(rdr); ex.push_back(E_NONE);
    // distance 3: one stall cycle
    st.push_back(wr);  ex.push_back(E_NONE);
    st.push_back(fl);  ex.push_back(E_NONE);
    st.push_back(fl);  ex.push_back(E_NONE);
    st.push_back(rdr); ex.push_back(E_STALL);
    st.push_back(rdr); ex.push_back(E_NONE);
    // distance 4: writer has retired
    st.push_back(wr);  ex.push_back(E_NONE);
    st.push_back(fl);  ex.push_back(E_NONE);
    st.push_back(fl);  ex.push_back(E_NONE);
    st.push_back(fl);  ex.push_back(E_NONE);
    st.push_back(rdr); ex.push_back(E_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL distance cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
    end
    checks++;
    if (stall_cycles !== 4'd3) begin
      errors++;
      $display("FAIL distance_stall_cycles: got %0d required 3", stall_cycles);
    end
  endtask

  task automatic test_x0_and_unused();
    stim_t st[4];
    exp_t  e;
    settle();
    st[0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);   // writes x0
    st[1] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);   // reads x0 on both ports
    st[2] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0);   // writes x3
    st[3] = mk(1, 3, 0, 3, 0, 0, 0, 0, 0);   // x3 in fields but not read
    for (int i = 0; i < 4; i++) begin
      drive(st[i], E_NONE);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL x0 cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL x0_stall_cycles: got %0d required 0", stall_cycles);
    end
  endtask

  task automatic test_branch_during_stall();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    settle();
    st[0] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0); ex[0] = E_NONE;
    st[1] = mk(1, 5, 1, 0, 0, 0, 0, 0, 0); ex[1] = E_STALL;
    st[2] = mk(1, 5, 1, 0, 0, 0, 0, 1, 0); ex[2] = E_BR;
    st[3] = mk(1, 5, 1, 0, 0, 0, 0, 0, 0); ex[3] = E_NONE;  // x5 still in WB, masked in FLUSH
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); ex[4] = E_NONE;
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL branch cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
      if (i == 3) begin
        checks++;
        if (ctrl_state !== 2'd2) begin
          errors++;
          $display("FAIL branch_state: got %0d required 2", ctrl_state);
        end
        checks++;
        if (flush_events !== 4'd1) begin
          errors++;
          $display("FAIL branch_flush_events: got %0d required 1", flush_events);
        end
      end
      if (i == 4) begin
        checks++;
        if (ctrl_state !== 2'd0) begin
          errors++;
          $display("FAIL branch_return_run: got %0d required 0", ctrl_state);
        end
      end
    end
  endtask

  task automatic test_saturation_clear();
    exp_t  e;
    exp_t  want;
    settle();
    // Self-dependent instruction repeated: one issue then three stall cycles, over and over.
    for (int i = 0; i <= 30; i++) begin
      want = ((i % 4) == 0) ? E_NONE : E_STALL;
      drive(mk(1, 5, 1, 0, 0, 5, 1, 0, (i == 30)), want);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL sat cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
      if (i == 29) begin
        checks++;
        if (stall_cycles !== 4'd15) begin
          errors++;
          $display("FAIL sat_stall_cycles: got %0d required 15", stall_cycles);
        end
      end
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE);
    e = exp_q.pop_front();
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL clear_over_stall: got %0d required 0", stall_cycles);
    end
    for (int i = 0; i < 18; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, (i == 17)), E_BR);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL flush_sat cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
      if (i == 17) begin
        checks++;
        if (flush_events !== 4'd15) begin
          errors++;
          $display("FAIL flush_events_sat: got %0d required 15", flush_events);
        end
      end
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE);
    e = exp_q.pop_front();
    checks++;
    if (flush_events !== 4'd0) begin
      errors++;
      $display("FAIL clear_over_branch: got %0d required 0", flush_events);
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    settle();
    drive(mk(1, 0, 0, 0, 0, 5, 1, 0, 0), E_NONE);
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0), E_STALL);
      e = exp_q.pop_front();
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
        errors++;
        $display("FAIL rst_stall cyc%0d: got %b required %b", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ctrl_state} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b required 000000",
               {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ctrl_state});
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_counter: got %0d required 0", stall_cycles);
    end
    @(negedge clock);
    reset_n = 1'b1;
    // Same reader as before: with the scoreboard emptied it must flow straight through.
    drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0), E_NONE);
    e = exp_q.pop_front();
    checks++;
    if ({pc_hold, if_id_hold, if_id_flush, id_ex_bubble} !== {e.hold, e.hold, e.flush, e.bubble}) begin
      errors++;
      $display("FAIL rst_release: got %b required %b",
               {pc_hold, if_id_hold, if_id_flush, id_ex_bubble}, {e.hold, e.hold, e.flush, e.bubble});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_back_to_back();
    test_distance();
    test_x0_and_unused();
    test_branch_during_stall();
    test_saturation_clear();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
